// File: rtl/traffic_pkg.sv
// Shared encodings and elaboration-time helpers for the traffic phase controller.
package traffic_pkg;

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // (base + off) mod n, valid while base + off < 2*n.
  function automatic int phase_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin picker: first pending phase after cur_phase, wrapping; cur_phase itself is scanned last.
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter int N_PHASE = 4,
  parameter int PW      = clog2(N_PHASE)
) (
  input  logic [N_PHASE-1:0] pending,
  input  logic [PW-1:0]      cur_phase,
  output logic [PW-1:0]      nxt_phase,
  output logic               any_valid
);

  // rot[j] holds pending[(cur_phase + 1 + j) mod N_PHASE].
  logic [N_PHASE-1:0] rot;
  assign rot = N_PHASE'(({pending, pending} >> cur_phase) >> 1);

  always_comb begin
    nxt_phase = PW'(phase_add(int'(cur_phase), 1, N_PHASE));
    any_valid = 1'b0;
    for (int j = N_PHASE - 1; j >= 0; j--) begin
      if (rot[j]) begin
        nxt_phase = PW'(phase_add(int'(cur_phase), j + 1, N_PHASE));
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase actuated intersection controller: GREEN -> YELLOW -> ALL_RED per phase, round-robin on demand.
// Optional emergency preemption is compiled in with macro TRAFFIC_PREEMPT_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_PHASE   = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  localparam int PW       = clog2(N_PHASE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [N_PHASE-1:0] demand,
  input  logic               preempt,
  input  logic [PW-1:0]      preempt_phase,
  output logic [N_PHASE-1:0] green,
  output logic [N_PHASE-1:0] yellow,
  output logic [N_PHASE-1:0] red,
  output logic [PW-1:0]      cur_phase,
  output logic               preempt_act,
  output logic [1:0]         state_dbg
);

  // The timer must also reach the yellow/all-red end counts if those exceed GREEN_MAX.
  localparam int TMAX_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int TMAX   = ((TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T) - 1;
  localparam int TW     = (clog2(TMAX + 1) < 1) ? 1 : clog2(TMAX + 1);

  localparam logic [TW-1:0] T_SAT       = TW'(TMAX);
  localparam logic [TW-1:0] GMIN_LAST   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_LAST   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);

  logic [1:0]         state, state_n;
  logic [PW-1:0]      cur_n, nxt_phase, nxt_n, target;
  logic [TW-1:0]      timer;
  logic [N_PHASE-1:0] pending, pending_n, cur_mask, enter_mask;
  logic [PW-1:0]      pick_phase;
  logic               pick_valid, other;
  logic               preempt_hold, preempt_go;

  traffic_rr_pick #(
    .N_PHASE (N_PHASE),
    .PW      (PW)
  ) u_pick (
    .pending   (pending),
    .cur_phase (cur_phase),
    .nxt_phase (pick_phase),
    .any_valid (pick_valid)
  );

  assign cur_mask  = N_PHASE'(1) << cur_phase;
  assign green     = (state == ST_GREEN)  ? cur_mask : '0;
  assign yellow    = (state == ST_YELLOW) ? cur_mask : '0;
  assign red       = ~(green | yellow);
  assign state_dbg = state;

  // cur_phase is scanned last, so a pick equal to cur_phase means nobody else is waiting.
  assign other = pick_valid && (pick_phase != cur_phase);

  always_comb begin
    preempt_hold = 1'b0;
    preempt_go   = 1'b0;
    target       = nxt_phase;
`ifdef TRAFFIC_PREEMPT_EN
    preempt_hold = preempt && (state == ST_GREEN) && (preempt_phase == cur_phase);
    preempt_go   = preempt && (state == ST_GREEN) && (preempt_phase != cur_phase);
    if (preempt) target = preempt_phase;
`endif
  end

  always_comb begin
    state_n = state;
    cur_n   = cur_phase;
    nxt_n   = nxt_phase;
    if (tick) begin
      case (state)
        ST_ALLRED: begin
          if (timer == ALLRED_LAST) begin
            state_n = ST_GREEN;
            cur_n   = target;
          end
        end
        ST_GREEN: begin
          if (preempt_go ||
              (!preempt_hold && other &&
               (((timer >= GMIN_LAST) && !demand[cur_phase]) || (timer >= GMAX_LAST)))) begin
            state_n = ST_YELLOW;
            nxt_n   = pick_phase;
          end
        end
        ST_YELLOW: begin
          if (timer == YELLOW_LAST) state_n = ST_ALLRED;
        end
        default: state_n = ST_ALLRED;
      endcase
    end
`ifdef TRAFFIC_PREEMPT_EN
    if (preempt) nxt_n = preempt_phase;
`endif
  end

  // Entering GREEN clears the served phase's request even if its detector is active that cycle.
  assign enter_mask = ((state != ST_GREEN) && (state_n == ST_GREEN)) ? (N_PHASE'(1) << cur_n) : '0;
  assign pending_n  = (pending | (demand & ~green)) & ~enter_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ALLRED;
      cur_phase <= '0;
      nxt_phase <= '0;
      timer     <= '0;
      pending   <= '0;
    end else begin
      state     <= state_n;
      cur_phase <= cur_n;
      nxt_phase <= nxt_n;
      pending   <= pending_n;
      if (state_n != state) timer <= '0;
      else if (tick && (timer != T_SAT)) timer <= timer + 1'b1;
    end
  end

`ifdef TRAFFIC_PREEMPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) preempt_act <= 1'b0;
    else        preempt_act <= preempt;
  end
`else
  logic unused_preempt;
  assign unused_preempt = ^{preempt, preempt_phase};
  assign preempt_act    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl (N_PHASE=4, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1).
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] demand;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic [3:0] green, yellow, red;
  logic [1:0] cur_phase;
  logic       preempt_act;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  traffic_phase_ctrl #(
    .N_PHASE   (4),
    .GREEN_MIN (4),
    .GREEN_MAX (8),
    .YELLOW_T  (2),
    .ALLRED_T  (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .demand        (demand),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .green         (green),
    .yellow        (yellow),
    .red           (red),
    .cur_phase     (cur_phase),
    .preempt_act   (preempt_act),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // Lamp safety monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(green | yellow) || ((green & yellow) !== 4'b0000)) begin
        failures++;
        $display("FAIL lamp_safety t=%0t got g=%b y=%b want onehot0 and no overlap", $time, green, yellow);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT one edge after green0 was entered (timer=0).
  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b1; demand = '0; preempt = 1'b0; preempt_phase = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b1; demand = '0; preempt = 1'b0; preempt_phase = '0;
    step(); step();
    checks++;
    if ({green, yellow, red, cur_phase, preempt_act} !== {4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got g=%b y=%b r=%b ph=%0d pa=%b want g=0000 y=0000 r=1111 ph=0 pa=0",
               green, yellow, red, cur_phase, preempt_act);
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if ({green, yellow, red} !== {4'b0000, 4'b0000, 4'b1111}) begin
      failures++;
      $display("FAIL reset_release_allred got g=%b y=%b r=%b want all red", green, yellow, red);
    end
    step();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({green, yellow, red, cur_phase} !== {4'b0001, 4'b0000, 4'b1110, 2'd0}) begin
        failures++;
        $display("FAIL idle_green0 k=%0d got g=%b y=%b r=%b ph=%0d want g=0001 y=0000 r=1110 ph=0",
                 k, green, yellow, red, cur_phase);
      end
      step();
    end
  endtask

  task automatic test_demand_pulse();
    logic [7:0] exp_v [5] = '{8'b0001_0000, 8'b0000_0001, 8'b0000_0001, 8'b0000_0000, 8'b0100_0000};
    do_reset();
    for (int k = 0; k < 5; k++) step();
    demand = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      demand = 4'b0000;
      checks++;
      if ({green, yellow, red} !== {exp_v[k], ~(exp_v[k][7:4] | exp_v[k][3:0])}) begin
        failures++;
        $display("FAIL demand_pulse k=%0d got g=%b y=%b r=%b want g=%b y=%b",
                 k, green, yellow, red, exp_v[k][7:4], exp_v[k][3:0]);
      end
    end
    checks++;
    if (cur_phase !== 2'd2) begin
      failures++;
      $display("FAIL demand_pulse_phase got %0d want 2", cur_phase);
    end
  endtask

  task automatic test_green_max();
    logic [7:0] exp_v [11] = '{8'b0001_0000, 8'b0001_0000, 8'b0001_0000, 8'b0001_0000,
                                 8'b0001_0000, 8'b0001_0000, 8'b0001_0000, 8'b0000_0001,
                                 8'b0000_0001, 8'b0000_0000, 8'b0010_0000};
    do_reset();
    demand = 4'b0011;
    for (int k = 0; k < 11; k++) begin
      step();
      checks++;
      if ({green, yellow, red} !== {exp_v[k], ~(exp_v[k][7:4] | exp_v[k][3:0])}) begin
        failures++;
        $display("FAIL green_max k=%0d got g=%b y=%b r=%b want g=%b y=%b",
                 k, green, yellow, red, exp_v[k][7:4], exp_v[k][3:0]);
      end
      if (k == 7) demand = 4'b0000;
    end
    checks++;
    if (cur_phase !== 2'd1) begin
      failures++;
      $display("FAIL green_max_phase got %0d want 1", cur_phase);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [14] = '{8'b0100_0000, 8'b0100_0000, 8'b0100_0000, 8'b0000_0100,
                                 8'b0000_0100, 8'b0000_0000, 8'b1000_0000, 8'b1000_0000,
                                 8'b1000_0000, 8'b1000_0000, 8'b0000_1000, 8'b0000_1000,
                                 8'b0000_0000, 8'b0010_0000};
    do_reset();
    demand = 4'b0100;
    step();
    demand = 4'b0000;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (green !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_setup got g=%b want 0100", green);
    end
    demand = 4'b1010;
    for (int k = 0; k < 14; k++) begin
      step();
      demand = 4'b0000;
      checks++;
      if ({green, yellow, red} !== {exp_v[k], ~(exp_v[k][7:4] | exp_v[k][3:0])}) begin
        failures++;
        $display("FAIL wrap_order k=%0d got g=%b y=%b r=%b want g=%b y=%b",
                 k, green, yellow, red, exp_v[k][7:4], exp_v[k][3:0]);
      end
    end
  endtask

  task automatic test_slow_tick();
    logic [7:0] exp_v [13] = '{8'b0001_0000, 8'b0001_0000, 8'b0001_0000, 8'b0000_0001,
                                 8'b0000_0001, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001,
                                 8'b0000_0001, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000,
                                 8'b0010_0000};
    do_reset();
    for (int k = 0; k < 5; k++) step();
    for (int k = 0; k < 13; k++) begin
      tick   = (k % 3 == 0);
      demand = (k == 0) ? 4'b0010 : 4'b0000;
      step();
      checks++;
      if ({green, yellow, red} !== {exp_v[k], ~(exp_v[k][7:4] | exp_v[k][3:0])}) begin
        failures++;
        $display("FAIL slow_tick k=%0d got g=%b y=%b r=%b want g=%b y=%b",
                 k, green, yellow, red, exp_v[k][7:4], exp_v[k][3:0]);
      end
    end
    tick = 1'b1;
  endtask

  task automatic test_reset_mid_yellow();
    do_reset();
    demand = 4'b0010;
    step();
    demand = 4'b0000;
    step(); step(); step();
    checks++;
    if (yellow !== 4'b0001) begin
      failures++;
      $display("FAIL mid_yellow_setup got y=%b want 0001", yellow);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({green, yellow, red, cur_phase} !== {4'b0000, 4'b0000, 4'b1111, 2'd0}) begin
      failures++;
      $display("FAIL async_reset got g=%b y=%b r=%b ph=%0d want all red ph=0", green, yellow, red, cur_phase);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({green, yellow, red} !== {4'b0000, 4'b0000, 4'b1111}) begin
      failures++;
      $display("FAIL post_reset_allred got g=%b y=%b r=%b want all red", green, yellow, red);
    end
    step();
    checks++;
    if ({green, cur_phase} !== {4'b0001, 2'd0}) begin
      failures++;
      $display("FAIL post_reset_green0 got g=%b ph=%0d want g=0001 ph=0", green, cur_phase);
    end
  endtask

`ifdef TRAFFIC_PREEMPT_EN
  task automatic test_preempt();
    logic [7:0] exp_v [9] = '{8'b0000_0001, 8'b0000_0001, 8'b0000_0000, 8'b1000_0000,
                                8'b1000_0000, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000,
                                8'b1000_0000};
    do_reset();
    step();
    preempt = 1'b1;
    preempt_phase = 2'd3;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if ({green, yellow, red, preempt_act} !== {exp_v[k], ~(exp_v[k][7:4] | exp_v[k][3:0]), 1'b1}) begin
        failures++;
        $display("FAIL preempt k=%0d got g=%b y=%b r=%b pa=%b want g=%b y=%b pa=1",
                 k, green, yellow, red, preempt_act, exp_v[k][7:4], exp_v[k][3:0]);
      end
    end
    preempt = 1'b0;
    step();
    checks++;
    if ({green, preempt_act} !== {4'b1000, 1'b0}) begin
      failures++;
      $display("FAIL preempt_release got g=%b pa=%b want g=1000 pa=0", green, preempt_act);
    end
  endtask
`else
  task automatic test_preempt();
    do_reset();
    step();
    preempt = 1'b1;
    preempt_phase = 2'd3;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({green, yellow, preempt_act} !== {4'b0001, 4'b0000, 1'b0}) begin
        failures++;
        $display("FAIL preempt_ignored k=%0d got g=%b y=%b pa=%b want g=0001 y=0000 pa=0",
                 k, green, yellow, preempt_act);
      end
    end
    preempt = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; tick = 1'b1; demand = '0; preempt = 1'b0; preempt_phase = '0;
    test_reset();
    test_demand_pulse();
    test_green_max();
    test_wrap();
    test_slow_tick();
    test_reset_mid_yellow();
    test_preempt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
